client_tx_arb: RTL

//  Round-robin arbiter sharing one Ethernet transmit port among n_clients tx clients
//  (each speaking the req/length/ack/strobe/data_out client protocol). Sits between
//  the clients and the MAC tx engine. It latches the winner's length, drives the

---
 rtl/client_tx_pkg.sv | 17 +
 rtl/client_tx_arb_if.sv | 37 +++
 rtl/rr_pick.sv | 32 +++
 rtl/client_tx_arb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/client_tx_pkg.sv
// Shared definitions for the client transmit arbiter.
//   state_t  : arbiter FSM states (IDLE, REQ, XFER, ZACK)
//   JUMBO_DW : default frame-length width (14 jumbo, 11 traditional Ethernet)
//   DATA_W   : payload byte width of the client protocol
package client_tx_pkg;

   localparam int unsigned JUMBO_DW = 14;
   localparam int unsigned DATA_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_ZACK = 2'd3
   } state_t;

endpackage

// File: rtl/client_tx_arb_if.sv
// Client-side and MAC-side signal bundle of the transmit arbiter.
//   cl_req/cl_length/cl_data : per-client request, frame length, payload byte
//   cl_ack/cl_strobe         : per-client ack and data strobe (one-hot or zero)
//   tx_req/tx_length/tx_data : request, latched length and muxed byte to the MAC
//   tx_ack/tx_strobe         : MAC accept and byte strobe
//   grant_id/busy            : current/last grant index, arbiter not idle
// Modports: master = arbiter side, slave = clients + MAC side.
interface client_tx_arb_if #(
   parameter int unsigned n_clients = 4,
   parameter int unsigned jumbo_dw  = client_tx_pkg::JUMBO_DW,
   parameter int unsigned idx_w     = 3
);

   logic [n_clients-1:0]                         cl_req;
   logic [n_clients*jumbo_dw-1:0]                cl_length;
   logic [n_clients*client_tx_pkg::DATA_W-1:0]   cl_data;
   logic [n_clients-1:0]                         cl_ack;
   logic [n_clients-1:0]                         cl_strobe;
   logic                                         tx_req;
   logic [jumbo_dw-1:0]                          tx_length;
   logic                                         tx_ack;
   logic                                         tx_strobe;
   logic [client_tx_pkg::DATA_W-1:0]             tx_data;
   logic [idx_w-1:0]                             grant_id;
   logic                                         busy;

   modport master (
      input  cl_req, cl_length, cl_data, tx_ack, tx_strobe,
      output cl_ack, cl_strobe, tx_req, tx_length, tx_data, grant_id, busy
   );

   modport slave (
      output cl_req, cl_length, cl_data, tx_ack, tx_strobe,
      input  cl_ack, cl_strobe, tx_req, tx_length, tx_data, grant_id, busy
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: the first set bit of req_i searching upward from
// ptr_i+1, wrapping modulo n.
//   req_i   : request vector
//   ptr_i   : index of the last served requester
//   valid_o : any request present
//   idx_o   : winning index (0 when valid_o=0)
module rr_pick #(
   parameter int unsigned n     = 4,
   parameter int unsigned idx_w = 2
) (
   input  logic [n-1:0]     req_i,
   input  logic [idx_w-1:0] ptr_i,
   output logic             valid_o,
   output logic [idx_w-1:0] idx_o
);

   logic [n-1:0] rot;
   int unsigned  start;

   always_comb begin
      start   = (32'(ptr_i) + 32'd1) % n;
      // rot[k] is the request of client (start+k) mod n
      rot     = n'({req_i, req_i} >> start);
      valid_o = |rot;
      idx_o   = '0;
      // descending scan so the lowest rotated position is assigned last
      for (int unsigned k = n; k > 0; k--) begin
         if (rot[k-1]) idx_o = idx_w'((start + k - 1) % n);
      end
   end

endmodule

// File: rtl/client_tx_arb.sv
// Round-robin arbiter sharing one Ethernet transmit port among n_clients
// clients. Latches the winner's length, drives tx_req, routes ack/strobe to
// the winner only and muxes the winner's payload byte onto tx_data.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : client/MAC signal bundle (master side)
// A stall of 2^wdog_w-1 cycles in REQ/XFER aborts the grant.
module client_tx_arb #(
   parameter int unsigned jumbo_dw  = client_tx_pkg::JUMBO_DW,
   parameter int unsigned n_clients = 4,
   parameter int unsigned idx_w     = 3,
   parameter int unsigned wdog_w    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   client_tx_arb_if.master bus
);

   import client_tx_pkg::*;

   state_t               state_q, state_d;
   logic [idx_w-1:0]     grant_q, grant_d;
   logic [idx_w-1:0]     rr_q, rr_d;
   logic [jumbo_dw-1:0]  len_q, len_d;
   logic                 txreq_q, txreq_d;
   logic                 seen_q, seen_d;
   logic [wdog_w-1:0]    wdog_q, wdog_d, wdog_inc;
   logic                 stall;

   logic                 pick_valid;
   logic [idx_w-1:0]     pick_idx;
   logic [jumbo_dw-1:0]  pick_len;
   logic [n_clients-1:0] grant_oh;
   logic [n_clients-1:0] ack, strobe;
   logic [DATA_W-1:0]    data_sel, data_o;

   rr_pick #(
      .n     (n_clients),
      .idx_w (idx_w)
   ) u_pick (
      .req_i   (bus.cl_req),
      .ptr_i   (rr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign pick_len = bus.cl_length[32'(pick_idx)*jumbo_dw +: jumbo_dw];
   assign data_sel = bus.cl_data[32'(grant_q)*DATA_W +: DATA_W];
   assign grant_oh = n_clients'(1) << grant_q;
   assign wdog_inc = wdog_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      len_d   = len_q;
      txreq_d = txreq_q;
      seen_d  = seen_q;
      wdog_d  = '0;
      stall   = 1'b0;
      ack     = '0;
      strobe  = '0;
      data_o  = '0;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               len_d   = pick_len;
               if (pick_len != '0) begin
                  txreq_d = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_ZACK;
               end
            end
         end
         ST_ZACK: begin
            ack     = grant_oh;
            rr_d    = grant_q;
            state_d = ST_IDLE;
         end
         ST_REQ: begin
            if (bus.tx_ack) begin
               ack     = grant_oh;
               txreq_d = 1'b0;
               seen_d  = 1'b0;
               state_d = ST_XFER;
            end else begin
               stall = !bus.tx_strobe;
            end
         end
         ST_XFER: begin
            if (bus.tx_strobe) begin
               strobe = grant_oh;
               data_o = data_sel;
               seen_d = 1'b1;
            end else if (seen_q) begin
               rr_d    = grant_q;
               len_d   = '0;
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A stall cycle is one without strobe and without state change; the
      // counter otherwise stays cleared. Reaching all-ones drops the grant and
      // advances the pointer so the stalled client loses its turn.
      if (stall) begin
         if (wdog_inc == '1) begin
            state_d = ST_IDLE;
            txreq_d = 1'b0;
            len_d   = '0;
            rr_d    = grant_q;
         end else begin
            wdog_d = wdog_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= idx_w'(n_clients - 1);
         len_q   <= '0;
         txreq_q <= 1'b0;
         seen_q  <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         len_q   <= len_d;
         txreq_q <= txreq_d;
         seen_q  <= seen_d;
         wdog_q  <= wdog_d;
      end
   end

   assign bus.cl_ack    = ack;
   assign bus.cl_strobe = strobe;
   assign bus.tx_req    = txreq_q;
   assign bus.tx_length = len_q;
   assign bus.tx_data   = data_o;
   assign bus.grant_id  = grant_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule
